// File: rtl/mem_pkg.sv
// Shared constants for the CPU data memory: bus widths and the big-endian
// byte-lane placement within a halfword.
package mem_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned BYTE       = 8;

  // Big-endian halfword: the even byte drives the high lane.
  localparam int unsigned HI_LANE_MSB = 15;
  localparam int unsigned HI_LANE_LSB = 8;
  localparam int unsigned LO_LANE_MSB = 7;
  localparam int unsigned LO_LANE_LSB = 0;

  typedef logic [BYTE-1:0] byte_t;

endpackage

// File: rtl/data_memory_if.sv
// Memory-stage bus between the CPU (master) and the data memory (slave).
interface data_memory_if;
    import mem_pkg::*;

    logic                  memoryWrite;
    logic                  memoryRead;
    logic                  sb;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] dataWrite;
    logic [DATA_WIDTH-1:0] dataRead;

    modport master (
        output memoryWrite, memoryRead, sb, address, dataWrite,
        input  dataRead
    );

    modport slave (
        input  memoryWrite, memoryRead, sb, address, dataWrite,
        output dataRead
    );

endinterface

// File: rtl/data_memory.sv
// Byte-addressed data memory: synchronous halfword/byte writes, combinational
// big-endian halfword reads, whole array cleared by asynchronous reset.
module data_memory
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned DATA_WIDTH = mem_pkg::DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    data_memory_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    byte_t mem [DEPTH];

    logic [ADDR_BITS-1:0]  a;
    logic [ADDR_BITS-1:0]  even_idx;
    logic [ADDR_BITS-1:0]  odd_idx;
    logic                  hi_we;
    logic                  lo_we;
    byte_t                 hi_data;
    logic [DATA_WIDTH-1:0] rdata;

    assign a        = bus.address[ADDR_BITS-1:0];
    assign even_idx = {a[ADDR_BITS-1:1], 1'b0};
    assign odd_idx  = {a[ADDR_BITS-1:1], 1'b1};

    // A byte store lands on whichever lane address[0] selects, always taking
    // the low data byte; a halfword store writes both lanes.
    always_comb begin
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_data = bus.dataWrite[HI_LANE_MSB:HI_LANE_LSB];
        if (bus.memoryWrite) begin
            if (bus.sb) begin
                hi_we   = ~a[0];
                lo_we   = a[0];
                hi_data = bus.dataWrite[LO_LANE_MSB:LO_LANE_LSB];
            end else begin
                hi_we = 1'b1;
                lo_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '{default: '0};
        end else begin
            if (hi_we) mem[even_idx] <= hi_data;
            if (lo_we) mem[odd_idx]  <= bus.dataWrite[LO_LANE_MSB:LO_LANE_LSB];
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.memoryRead) begin
            rdata = {mem[even_idx], mem[odd_idx]};
        end
    end

    assign bus.dataRead = rdata;

    // Upper address bits alias onto the array and are intentionally ignored.
    if (ADDR_BITS < ADDR_WIDTH) begin : gen_alias
        logic unused_addr;
        assign unused_addr = ^bus.address[ADDR_WIDTH-1:ADDR_BITS];
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// traffic checked against a byte-array reference model.
module tb_data_memory;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    byte unsigned mdl [256];

    data_memory_if bus ();

    data_memory dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic void mdl_clear();
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    endfunction

    function automatic logic [15:0] mdl_read(input logic [15:0] addr);
        int e;
        e = (int'(addr) % 256) & ~1;
        return {mdl[e], mdl[e + 1]};
    endfunction

    function automatic void mdl_write(input logic [15:0] addr, input logic [15:0] d,
                                      input logic s);
        int x;
        x = int'(addr) % 256;
        if (s) begin
            mdl[x] = d[7:0];
        end else begin
            mdl[x & ~1]       = d[15:8];
            mdl[(x & ~1) + 1] = d[7:0];
        end
    endfunction

    task automatic wr(input logic [15:0] addr, input logic [15:0] d, input logic s);
        @(negedge clk);
        bus.memoryWrite = 1'b1;
        bus.memoryRead  = 1'b0;
        bus.sb          = s;
        bus.address     = addr;
        bus.dataWrite   = d;
        @(posedge clk);
        #1;
        if (reset_n) mdl_write(addr, d, s);
        bus.memoryWrite = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic en, output logic [15:0] v);
        @(negedge clk);
        bus.memoryWrite = 1'b0;
        bus.memoryRead  = en;
        bus.address     = addr;
        bus.dataWrite   = 16'hFFFF;
        #1;
        v = bus.dataRead;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset_n         = 1'b0;
        bus.memoryWrite = 1'b0;
        bus.memoryRead  = 1'b1;
        bus.sb          = 1'b0;
        bus.address     = 16'h0000;
        bus.dataWrite   = 16'h0000;
        mdl_clear();
        #20;
        reset_n = 1'b1;
        rd(16'h0000, 1'b1, v);
        checks++;
        if (v !== 16'h0000) begin
            $display("FAIL reset_read: got %h want 0000", v);
            failures++;
        end
    endtask

    task automatic test_halfword();
        logic [15:0] v;
        logic [15:0] addrs [3] = '{16'hFFFA, 16'h0000, 16'h00FA};
        logic [15:0] exps  [3] = '{16'h0045, 16'h0000, 16'h0045};
        wr(16'hFFFA, 16'h0045, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i], 1'b1, v);
            checks++;
            if (v !== exps[i]) begin
                $display("FAIL halfword_read[%h]: got %h want %h", addrs[i], v, exps[i]);
                failures++;
            end
        end
    endtask

    task automatic test_byte();
        logic [15:0] v;
        wr(16'h0010, 16'h1234, 1'b0);
        wr(16'h0011, 16'hABCD, 1'b1);
        rd(16'h0010, 1'b1, v);
        checks++;
        if (v !== 16'h12CD) begin
            $display("FAIL byte_odd: got %h want 12cd", v);
            failures++;
        end
        wr(16'h0010, 16'h0077, 1'b1);
        rd(16'h0010, 1'b1, v);
        checks++;
        if (v !== 16'h77CD) begin
            $display("FAIL byte_even: got %h want 77cd", v);
            failures++;
        end
    endtask

    task automatic test_read_gate();
        logic [15:0] v;
        rd(16'h00FA, 1'b0, v);
        checks++;
        if (v !== 16'h0000) begin
            $display("FAIL read_gated: got %h want 0000", v);
            failures++;
        end
        rd(16'h00FB, 1'b1, v);
        checks++;
        if (v !== 16'h0045) begin
            $display("FAIL odd_halfword: got %h want 0045", v);
            failures++;
        end
    endtask

    task automatic test_write_disabled();
        logic [15:0] v;
        @(negedge clk);
        bus.memoryWrite = 1'b0;
        bus.address     = 16'h00FA;
        bus.dataWrite   = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            bus.sb = i[0];
            @(negedge clk);
        end
        rd(16'h00FA, 1'b1, v);
        checks++;
        if (v !== 16'h0045) begin
            $display("FAIL write_disabled: got %h want 0045", v);
            failures++;
        end
    endtask

    task automatic test_read_after_write();
        logic [15:0] old_v;
        logic [15:0] d;
        d = 16'hC3A5;
        @(negedge clk);
        bus.memoryWrite = 1'b1;
        bus.memoryRead  = 1'b1;
        bus.sb          = 1'b0;
        bus.address     = 16'h0040;
        bus.dataWrite   = d;
        old_v           = mdl_read(16'h0040);
        #1;
        checks++;
        if (bus.dataRead !== old_v) begin
            $display("FAIL raw_before_edge: got %h want %h", bus.dataRead, old_v);
            failures++;
        end
        @(posedge clk);
        #1;
        mdl_write(16'h0040, d, 1'b0);
        checks++;
        if (bus.dataRead !== 16'hC3A5) begin
            $display("FAIL raw_after_edge: got %h want c3a5", bus.dataRead);
            failures++;
        end
        bus.memoryWrite = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        wr(16'h0020, 16'h5555, 1'b0);
        rd(16'h0020, 1'b1, v);
        checks++;
        if (v !== 16'h5555) begin
            $display("FAIL pre_reset_store: got %h want 5555", v);
            failures++;
        end
        // Drop reset well away from any clock edge.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        mdl_clear();
        #1;
        checks++;
        if (bus.dataRead !== 16'h0000) begin
            $display("FAIL async_reset_clear: got %h want 0000", bus.dataRead);
            failures++;
        end
        @(negedge clk);
        bus.memoryWrite = 1'b1;
        bus.sb          = 1'b0;
        bus.dataWrite   = 16'h9999;
        @(posedge clk);
        #1;
        bus.memoryWrite = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(16'h0020, 1'b1, v);
        checks++;
        if (v !== 16'h0000) begin
            $display("FAIL write_during_reset: got %h want 0000", v);
            failures++;
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [15:0] addr;
        logic [15:0] d;
        logic [15:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                wr(addr, d, 1'($urandom_range(0, 1)));
            end else begin
                exp_v = mdl_read(addr);
                rd(addr, 1'b1, v);
                checks++;
                if (v !== exp_v) begin
                    $display("FAIL random_read[%0d] addr=%h: got %h want %h", i, addr, v, exp_v);
                    failures++;
                end
            end
        end
        for (int i = 0; i < 256; i += 2) begin
            exp_v = mdl_read(16'(i));
            rd(16'(i) | 16'h8000, 1'b1, v);
            checks++;
            if (v !== exp_v) begin
                $display("FAIL sweep_read addr=%h: got %h want %h", i, v, exp_v);
                failures++;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_halfword();
        test_byte();
        test_read_gate();
        test_write_disabled();
        test_read_after_write();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed data memory for the CPU's memory stage, with a 16-bit address and 16-bit data path.
- Supports halfword (16-bit) writes, byte writes (sb = store byte) and halfword reads.
- Writes are synchronous to the clock; reads are combinational.
- The whole array clears to zero on an asynchronous active-low reset.

Parameters:
- ADDR_BITS, 8, number of low address bits that index the array. Size = 2^ADDR_BITS bytes. Upper address bits are ignored, so addresses alias.
- DATA_WIDTH, 16, data bus width. Fixed at 16 and not meant to be overridden.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- memoryWrite  input  1  write enable, sampled on the rising clk edge.
- memoryRead  input  1  read enable, combinational.
- sb  input  1  store-byte select: 1 = byte write, 0 = halfword write.
- address  input  16  byte address; bits [ADDR_BITS-1:0] are used.
- dataWrite  input  16  write data.
- dataRead  output  16  read data.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Storage: 2^ADDR_BITS bytes, index a = address[ADDR_BITS-1:0].
- Endianness: big-endian halfwords.
  - The halfword at even base e consists of byte[e] (bits 15:8) and byte[e+1] (bits 7:0).
  - For halfword access, e = a with bit 0 cleared; address[0] is ignored.
- Reset: while reset_n=0, every byte is 0. Reset takes effect immediately, independent of clk, and blocks writes while asserted.
  - Reset mid-operation discards any pending write.
  - Reads during reset return 0x0000 when memoryRead=1.
- Write (rising clk, reset_n=1, memoryWrite=1):
  - sb=0: byte[e] <= dataWrite[15:8]; byte[e+1] <= dataWrite[7:0].
  - sb=1: byte[a] <= dataWrite[7:0] (exact byte address, odd allowed). The other byte and dataWrite[15:8] are ignored.
- Read (combinational, zero latency):
  - memoryRead=1: dataRead = {byte[e], byte[e+1]}.
  - memoryRead=0: dataRead = 16'h0000.
  - sb has no effect on reads.
- Simultaneous memoryRead=1 and memoryWrite=1 at the same address:
  - Before the edge, dataRead shows old contents.
  - After the edge, dataRead shows the new contents in the same cycle (read-after-write visible combinationally).
- memoryWrite=0: no state change regardless of sb or dataWrite.
- Aliasing / wrap-around: addresses differing only in bits above ADDR_BITS-1 hit the same location. With the default ADDR_BITS=8, 0xFFFA and 0x00FA are the same location.
- X/undriven memoryRead or memoryWrite before first use is not required to be handled. The bench drives both after reset release.

Decomposition:
- Shared package (mem_pkg) holds:
  - DATA_WIDTH = 16
  - ADDR_WIDTH = 16
  - BYTE = 8
  - the halfword byte-lane ordering constants (HI_LANE = 15:8, LO_LANE = 7:0)
- No sub-module. A single module with a byte array, a write-enable decode for the two lanes, and a combinational read mux is natural.

Test Plan:
- Reset then read: reset_n=0 for 20 time units, release, memoryRead=1, address=0x0000 -> dataRead=0x0000.
- Halfword write then read-back:
  - Write cycle: memoryWrite=1, sb=0, address=0xFFFA, dataWrite=0x0045, one edge.
  - Read cycle: memoryWrite=0, memoryRead=1, address=0xFFFA, dataWrite=0xFFFF -> dataRead=0x0045.
  - Also address=0x0000 -> 0x0000, and address=0x00FA -> 0x0045 (alias).
- Byte write:
  - Prior state: halfword 0x1234 written at 0x0010.
  - Write sb=1, address=0x0011, dataWrite=0xABCD -> read 0x0010 returns 0x12CD.
  - Then sb=1, address=0x0010, dataWrite=0x0077 -> read 0x0010 returns 0x77CD.
- Read gating and odd halfword address:
  - memoryRead=0 with stored 0x0045 at 0x00FA -> dataRead=0x0000.
  - memoryRead=1, address=0x00FB -> 0x0045.
- Write disabled: memoryWrite=0, address=0x00FA, dataWrite=0xBEEF over several edges -> read still 0x0045.
- Async reset mid-operation:
  - Store 0x5555 at 0x0020.
  - Assert reset_n=0 between clock edges -> read at 0x0020 returns 0x0000 immediately.
  - A write attempted while reset is low has no effect after release.
